// File: rtl/hdc_class_pkg.sv
// Shared types and helpers for the class-hypervector store and its frame streamer.
package hdc_class_pkg;

    typedef enum logic {IDLE, STREAM} state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/class_hvec_ram.sv
// One-write/one-read word array with a registered read port; a same-cycle write and read
// of one address returns the previous contents.
module class_hvec_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 24,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/class_hvec_stream.sv
// Writable class-hypervector store that streams one class, or a sweep of all classes,
// one frame per cycle over a valid/ready handshake.
module class_hvec_stream
    import hdc_class_pkg::*;
#(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int NUM_CLASSES        = 8,
    parameter int NUM_FRAMES         = 3,
    localparam int CLASS_ID_W        = id_width(NUM_CLASSES),
    localparam int FRAME_ID_W        = id_width(NUM_FRAMES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [CLASS_ID_W-1:0]         wr_class,
    input  logic [FRAME_ID_W-1:0]         wr_frame,
    input  logic [DI_PARALLEL_W_BITS-1:0] wr_data,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_all,
    input  logic [CLASS_ID_W-1:0]         req_class,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DI_PARALLEL_W_BITS-1:0] out_data,
    output logic [CLASS_ID_W-1:0]         out_class,
    output logic [FRAME_ID_W-1:0]         out_frame,
    output logic                          out_last_frame,
    output logic                          out_last,
    output logic                          req_err
);

    localparam int DEPTH  = NUM_CLASSES * NUM_FRAMES;
    localparam int ADDR_W = id_width(DEPTH);
    localparam logic [CLASS_ID_W-1:0] LAST_CLASS = CLASS_ID_W'(NUM_CLASSES - 1);
    localparam logic [FRAME_ID_W-1:0] LAST_FRAME = FRAME_ID_W'(NUM_FRAMES - 1);

    typedef struct packed {
        logic [DI_PARALLEL_W_BITS-1:0] data;
        logic [CLASS_ID_W-1:0]         cls;
        logic [FRAME_ID_W-1:0]         frame;
        logic                          last_frame;
        logic                          last;
    } beat_t;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CLASS_ID_W-1:0] c,
                                                  input logic [FRAME_ID_W-1:0] f);
        return ADDR_W'(int'(c) * NUM_FRAMES + int'(f));
    endfunction

    state_e                        state, state_next;
    logic                          valid, valid_next;
    logic                          err_next;
    logic                          sweep;
    logic                          load;
    logic [CLASS_ID_W-1:0]         cur_class, load_class;
    logic [FRAME_ID_W-1:0]         cur_frame, load_frame;
    logic                          wr_ok;
    logic                          at_last_frame, at_last;
    logic [DI_PARALLEL_W_BITS-1:0] rd_data;
    beat_t                         beat;

    assign wr_ok = wr_en && (int'(wr_class) < NUM_CLASSES) && (int'(wr_frame) < NUM_FRAMES);

    // The read register doubles as the out_data register, so it holds across stalls.
    class_hvec_ram #(
        .DATA_W (DI_PARALLEL_W_BITS),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (addr_of(wr_class, wr_frame)),
        .wr_data (wr_data),
        .rd_en   (load),
        .rd_addr (addr_of(load_class, load_frame)),
        .rd_data (rd_data)
    );

    assign at_last_frame = (cur_frame == LAST_FRAME);
    assign at_last       = at_last_frame && (!sweep || cur_class == LAST_CLASS);

    always_comb begin
        state_next = state;
        valid_next = valid;
        err_next   = 1'b0;
        load       = 1'b0;
        load_class = cur_class;
        load_frame = cur_frame;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!req_all && int'(req_class) >= NUM_CLASSES) begin
                        err_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        load_class = req_all ? '0 : req_class;
                        load_frame = '0;
                        valid_next = 1'b1;
                        state_next = STREAM;
                    end
                end
            end
            STREAM: begin
                if (valid && out_ready) begin
                    if (at_last) begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end else begin
                        load = 1'b1;
                        if (at_last_frame) begin
                            load_frame = '0;
                            load_class = cur_class + 1'b1;
                        end else begin
                            load_frame = cur_frame + 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= 1'b0;
            req_err   <= 1'b0;
            sweep     <= 1'b0;
            cur_class <= '0;
            cur_frame <= '0;
        end else begin
            state   <= state_next;
            valid   <= valid_next;
            req_err <= err_next;
            if (load) begin
                cur_class <= load_class;
                cur_frame <= load_frame;
            end
            if (state == IDLE && load) begin
                sweep <= req_all;
            end
        end
    end

    assign beat = '{data:       rd_data,
                    cls:        cur_class,
                    frame:      cur_frame,
                    last_frame: valid && at_last_frame,
                    last:       valid && at_last};

    assign out_valid      = valid;
    assign out_data       = beat.data;
    assign out_class      = beat.cls;
    assign out_frame      = beat.frame;
    assign out_last_frame = beat.last_frame;
    assign out_last       = beat.last;

endmodule

// File: tb/tb_class_hvec_stream.sv
// Bench for class_hvec_stream: table-driven requests plus randomized writes/backpressure
// checked against a frame-array model, and a small 6-class, 1-frame instance for edge cases.
module tb_class_hvec_stream;

    localparam int NC = 8;
    localparam int NF = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, req_valid, req_ready, req_all, out_valid, out_ready;
    logic [2:0]  wr_class, req_class, out_class;
    logic [1:0]  wr_frame, out_frame;
    logic [63:0] wr_data, out_data;
    logic        out_last_frame, out_last, req_err;

    logic        b_wr_en, b_req_valid, b_req_ready, b_req_all, b_out_valid, b_out_ready;
    logic [2:0]  b_wr_class, b_req_class, b_out_class;
    logic [0:0]  b_wr_frame, b_out_frame;
    logic [15:0] b_wr_data, b_out_data;
    logic        b_out_last_frame, b_out_last, b_req_err;

    int          total = 0;
    int          bad = 0;
    logic [63:0] mmem [NC][NF];
    logic [15:0] bmem [6];

    typedef struct {
        bit all;
        int cls;
        int mode;
        int beats;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    class_hvec_stream #(.DI_PARALLEL_W_BITS(64), .NUM_CLASSES(NC), .NUM_FRAMES(NF)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_class(wr_class), .wr_frame(wr_frame),
        .wr_data(wr_data), .req_valid(req_valid), .req_ready(req_ready), .req_all(req_all),
        .req_class(req_class), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_class(out_class), .out_frame(out_frame),
        .out_last_frame(out_last_frame), .out_last(out_last), .req_err(req_err)
    );

    class_hvec_stream #(.DI_PARALLEL_W_BITS(16), .NUM_CLASSES(6), .NUM_FRAMES(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_class(b_wr_class), .wr_frame(b_wr_frame),
        .wr_data(b_wr_data), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_all(b_req_all), .req_class(b_req_class), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_class(b_out_class),
        .out_frame(b_out_frame), .out_last_frame(b_out_last_frame), .out_last(b_out_last),
        .req_err(b_req_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int c, input int f);
        return {8'(c), 8'(f), 16'h5A5A, 32'hC1A5_0000 + 32'(c * 16 + f)};
    endfunction

    task automatic apply_stimulus(input int c, input int f, input logic [63:0] d);
        wr_en    = 1'b1;
        wr_class = 3'(c);
        wr_frame = 2'(f);
        wr_data  = d;
        tick();
        wr_en    = 1'b0;
    endtask

    // mode 0: always ready, 1: ready every other cycle, 2: random ready plus random writes
    task automatic run_req(input bit all, input int cls, input int mode, output int beats);
        int          pc[$];
        int          pf[$];
        int          idx;
        int          wc;
        int          wf;
        bit          done;
        bit          do_wr;
        bit          hs;
        logic [63:0] hold;
        logic [63:0] wd;
        beats = 0;
        if (all) begin
            for (int c = 0; c < NC; c++)
                for (int f = 0; f < NF; f++) begin
                    pc.push_back(c);
                    pf.push_back(f);
                end
        end else begin
            for (int f = 0; f < NF; f++) begin
                pc.push_back(cls);
                pf.push_back(f);
            end
        end
        check_output("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_all   = all;
        req_class = 3'(cls);
        out_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        req_all   = 1'b0;
        idx  = 0;
        hold = mmem[pc[0]][pf[0]];
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            check_output("stream_valid", out_valid, 1);
            check_output("stream_busy", req_ready, 0);
            check_output("beat_data", out_data, hold);
            check_output("beat_tag", {out_class, out_frame, out_last_frame, out_last},
                         {3'(pc[idx]), 2'(pf[idx]), pf[idx] == NF - 1, idx == pc.size() - 1});
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc % 2 == 0);
            else out_ready = 1'($urandom_range(0, 1));
            do_wr    = (mode == 2) && ($urandom_range(0, 3) == 0);
            wc       = $urandom_range(0, NC - 1);
            wf       = $urandom_range(0, 3);
            wd       = {$urandom, $urandom};
            wr_en    = do_wr;
            wr_class = 3'(wc);
            wr_frame = 2'(wf);
            wr_data  = wd;
            hs       = out_ready;
            tick();
            wr_en = 1'b0;
            if (hs) begin
                beats++;
                if (idx == pc.size() - 1) done = 1'b1;
                else begin
                    idx++;
                    hold = mmem[pc[idx]][pf[idx]];
                end
            end
            if (do_wr && wf < NF) mmem[wc][wf] = wd;
        end
        check_output("stream_end", done, 1);
        check_output("idle_after", {out_valid, req_ready, req_err}, 3'b010);
        out_ready = 1'b0;
    endtask

    initial begin
        int          nb;
        bit          found;
        logic [63:0] old51;
        rst = 1'b1;
        wr_en = 0; wr_class = 0; wr_frame = 0; wr_data = 0;
        req_valid = 0; req_all = 0; req_class = 0; out_ready = 0;
        b_wr_en = 0; b_wr_class = 0; b_wr_frame = 0; b_wr_data = 0;
        b_req_valid = 0; b_req_all = 0; b_req_class = 0; b_out_ready = 0;
        vecs[0] = '{0, 5, 0, 3};
        vecs[1] = '{1, 0, 1, 24};
        vecs[2] = '{0, 1, 0, 3};
        vecs[3] = '{0, 7, 1, 3};
        vecs[4] = '{1, 2, 2, 24};
        vecs[5] = '{0, 0, 2, 3};
        repeat (3) tick();
        rst = 1'b0;
        check_output("reset_flags", {out_valid, req_ready, req_err, out_last, out_last_frame},
                     5'b01000);
        check_output("reset_pos", {out_class, out_frame}, 0);
        check_output("reset_data", out_data, 0);
        check_output("reset_b", {b_out_valid, b_req_ready, b_req_err}, 3'b010);

        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) begin
                apply_stimulus(c, f, pat(c, f));
                mmem[c][f] = pat(c, f);
            end
        apply_stimulus(0, 3, 64'hDEAD_BEEF_DEAD_BEEF);

        foreach (vecs[i]) begin
            run_req(vecs[i].all, vecs[i].cls, vecs[i].mode, nb);
            check_output($sformatf("vec%0d_beats", i), nb, vecs[i].beats);
            tick();
        end

        // Stall on (5,1) while rewriting (5,2) and (5,1) itself.
        req_valid = 1'b1; req_all = 1'b0; req_class = 3'd5; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check_output("mid_b0", {out_valid, out_class, out_frame}, {1'b1, 3'd5, 2'd0});
        tick();
        old51 = mmem[5][1];
        out_ready = 1'b0;
        apply_stimulus(5, 2, 64'h2222_0000_5252_AAAA);
        apply_stimulus(5, 1, 64'h1111_0000_5151_BBBB);
        mmem[5][2] = 64'h2222_0000_5252_AAAA;
        mmem[5][1] = 64'h1111_0000_5151_BBBB;
        check_output("mid_b1_tag", {out_valid, out_class, out_frame, out_last}, {1'b1, 3'd5, 2'd1, 1'b0});
        check_output("mid_b1_data", out_data, old51);
        out_ready = 1'b1;
        tick();
        check_output("mid_b2_tag", {out_valid, out_class, out_frame, out_last}, {1'b1, 3'd5, 2'd2, 1'b1});
        check_output("mid_b2_data", out_data, 64'h2222_0000_5252_AAAA);
        tick();
        out_ready = 1'b0;
        check_output("mid_done", {out_valid, req_ready}, 2'b01);
        tick();

        // Reset in the middle of a sweep at beat (3,1).
        req_valid = 1'b1; req_all = 1'b1; out_ready = 1'b1;
        tick();
        req_valid = 1'b0; req_all = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_class == 3'd3 && out_frame == 2'd1) found = 1'b1;
            else tick();
        end
        check_output("abort_reach", found, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        check_output("abort_flags", {out_valid, req_ready, req_err, out_last, out_last_frame},
                     5'b01000);
        check_output("abort_data", out_data, 0);
        tick();
        check_output("abort_idle", {out_valid, req_ready}, 2'b01);
        run_req(1'b0, 3, 0, nb);
        check_output("abort_restart_beats", nb, 3);
        tick();

        for (int r = 0; r < 12; r++) begin
            bit rall;
            int rcls;
            rall = 1'($urandom_range(0, 3) == 0);
            rcls = $urandom_range(0, NC - 1);
            run_req(rall, rcls, 2, nb);
            check_output("rand_beats", nb, rall ? NC * NF : NF);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Six classes of one frame each: class index 6 is representable but invalid.
        for (int c = 0; c < 6; c++) begin
            b_wr_en = 1'b1; b_wr_class = 3'(c); b_wr_frame = 1'b0;
            b_wr_data = 16'h1000 + 16'(c * 16'h0111);
            bmem[c] = b_wr_data;
            tick();
        end
        b_wr_en = 1'b0;
        check_output("b_bad_ready", b_req_ready, 1);
        b_req_valid = 1'b1; b_req_all = 1'b0; b_req_class = 3'd6;
        tick();
        b_req_valid = 1'b0;
        check_output("b_err_pulse", {b_req_err, b_out_valid, b_req_ready}, 3'b101);
        tick();
        check_output("b_err_clear", {b_req_err, b_out_valid, b_req_ready}, 3'b001);
        b_req_valid = 1'b1; b_req_all = 1'b1; b_out_ready = 1'b1;
        tick();
        b_req_valid = 1'b0; b_req_all = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_output("b_sweep_tag", {b_out_valid, b_out_class, b_out_frame, b_out_last_frame, b_out_last},
                         {1'b1, 3'(i), 1'b0, 1'b1, i == 5});
            check_output("b_sweep_data", b_out_data, bmem[i]);
            tick();
        end
        check_output("b_sweep_end", {b_out_valid, b_req_ready}, 2'b01);
        b_out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
